// File: rtl/key_event.sv
// Key event classifier: turns filtered press/release pulses and the refclk tick
// into short, long, repeat and double-click 1-clk event pulses.
module key_event #(
  parameter int CW = 16
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          en,
  input  logic          refclk,
  input  logic          act_edge,
  input  logic          inact_edge,
  input  logic          dbl_en,
  input  logic          rpt_en,
  input  logic [CW-1:0] long_th,
  input  logic [CW-1:0] rpt_iv,
  input  logic [CW-1:0] dbl_win,
  output logic          ev_short,
  output logic          ev_long,
  output logic          ev_repeat,
  output logic          ev_double,
  output logic          busy
);

  localparam logic [2:0] IDLE   = 3'd0;
  localparam logic [2:0] PRESS  = 3'd1;
  localparam logic [2:0] LONG   = 3'd2;
  localparam logic [2:0] WAIT2  = 3'd3;
  localparam logic [2:0] PRESS2 = 3'd4;

  logic [2:0]    state, nxt;
  logic [CW-1:0] cnt, cnt_nxt;
  logic          cnt_clr;
  logic          act, inact;
  logic          long_exp, rpt_exp, dbl_exp;
  logic          s_nxt, l_nxt, r_nxt, d_nxt;

  // Threshold of 0 behaves as 1; compare at CW+1 bits so cnt+1 never wraps.
  function automatic logic reached(input logic [CW-1:0] c, input logic [CW-1:0] th);
    logic [CW:0] eff;
    eff = (th == '0) ? (CW+1)'(1) : {1'b0, th};
    return ({1'b0, c} + (CW+1)'(1)) >= eff;
  endfunction

  always_comb begin
    nxt      = state;
    cnt_clr  = 1'b0;
    s_nxt    = 1'b0;
    l_nxt    = 1'b0;
    r_nxt    = 1'b0;
    d_nxt    = 1'b0;
    act      = act_edge & ~inact_edge;
    inact    = inact_edge & ~act_edge;
    long_exp = refclk && reached(cnt, long_th);
    rpt_exp  = refclk && reached(cnt, rpt_iv);
    dbl_exp  = refclk && reached(cnt, dbl_win);
    case (state)
      IDLE: if (act) nxt = PRESS;
      PRESS: begin
        if (long_exp) begin
          nxt   = LONG;
          l_nxt = 1'b1;
        end else if (inact) begin
          if (dbl_en) nxt = WAIT2;
          else begin
            nxt   = IDLE;
            s_nxt = 1'b1;
          end
        end
      end
      LONG: begin
        // Release takes precedence over a repeat falling in the same cycle.
        if (inact) nxt = IDLE;
        else if (rpt_en && rpt_exp) begin
          r_nxt   = 1'b1;
          cnt_clr = 1'b1;
        end
      end
      WAIT2: begin
        if (!dbl_en) begin
          nxt   = IDLE;
          s_nxt = 1'b1;
        end else if (act) nxt = PRESS2;
        else if (dbl_exp) begin
          nxt   = IDLE;
          s_nxt = 1'b1;
        end
      end
      PRESS2: begin
        if (long_exp) begin
          nxt   = LONG;
          s_nxt = 1'b1;
          l_nxt = 1'b1;
        end else if (inact) begin
          nxt   = IDLE;
          d_nxt = 1'b1;
        end
      end
      default: nxt = IDLE;
    endcase
    if (!en) begin
      nxt   = IDLE;
      s_nxt = 1'b0;
      l_nxt = 1'b0;
      r_nxt = 1'b0;
      d_nxt = 1'b0;
    end
  end

  always_comb begin
    cnt_nxt = cnt;
    if (!en || (nxt != state) || cnt_clr) cnt_nxt = '0;
    else if (refclk && (cnt != '1)) cnt_nxt = cnt + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      cnt       <= '0;
      ev_short  <= 1'b0;
      ev_long   <= 1'b0;
      ev_repeat <= 1'b0;
      ev_double <= 1'b0;
      busy      <= 1'b0;
    end else begin
      state     <= nxt;
      cnt       <= cnt_nxt;
      ev_short  <= s_nxt;
      ev_long   <= l_nxt;
      ev_repeat <= r_nxt;
      ev_double <= d_nxt;
      busy      <= (nxt != IDLE);
    end
  end

endmodule

// File: doc/key_event.md
Name: key_event

Overview:
- Button/key event classifier that sits directly downstream of the digital noise filter.
- Consumes the filter's active-edge and inactive-edge 1-clk pulses plus the shared refclk tick.
- Produces 1-clk event pulses: short press, long press, auto-repeat and double-click.
- Feeds the board's key-status registers and interrupt logic.

Parameters:
CW, 16, width of time counter and threshold ports (unit = refclk ticks)

Ports:
clk  input  1  global clock; single clock domain
rst  input  1  reset, synchronous, active-high
en  input  1  block enable; 0 forces IDLE, suppresses all events
refclk  input  1  timebase tick, 1-clk pulse (same tick that drives the filter)
act_edge  input  1  filtered key press, 1-clk pulse
inact_edge  input  1  filtered key release, 1-clk pulse
dbl_en  input  1  1: double-click detection enabled
rpt_en  input  1  1: auto-repeat enabled while held long
long_th  input  CW  long-press threshold, refclk ticks
rpt_iv  input  CW  repeat interval, refclk ticks
dbl_win  input  CW  double-click window after first release, refclk ticks
ev_short  output  1  short press event, 1-clk pulse
ev_long  output  1  long press event, 1-clk pulse
ev_repeat  output  1  repeat event, 1-clk pulse
ev_double  output  1  double-click event, 1-clk pulse
busy  output  1  1 when state != IDLE

Behaviour:
- All outputs are registered. Reset (rst=1 at posedge clk): state=IDLE, cnt=0, all ev_* = 0, busy = 0.
- Event latency: each pulse is high for exactly the one clk after the triggering edge or tick.
- Threshold semantics:
  - Effective threshold = max(port value, 1); a value of 0 behaves as 1.
  - "Expire" means refclk=1 and (cnt+1) >= threshold, computed at CW+1 bits; no wrap.
  - Thresholds are sampled live each cycle. Lowering one below the current cnt expires on the next refclk.
- cnt: cleared on every state change; otherwise increments by 1 on each refclk; saturates at all-ones.
- Edge conflicts:
  - act_edge and inact_edge in the same cycle: both ignored.
  - An edge that is illegal for the current state (for example, act_edge in PRESS) is ignored.
- State transitions:
  - IDLE: act_edge -> PRESS.
  - PRESS:
    - inact_edge with dbl_en=1 -> WAIT2, no event.
    - inact_edge with dbl_en=0 -> IDLE, ev_short.
    - long_th expire (checked before inact_edge in the same cycle) -> LONG, ev_long.
  - LONG:
    - rpt_en=1 and rpt_iv expire -> ev_repeat, cnt cleared, stay in LONG.
    - inact_edge -> IDLE, no event.
  - WAIT2:
    - act_edge -> PRESS2.
    - dbl_win expire -> IDLE, ev_short.
    - If both occur in the same cycle, act_edge wins.
  - PRESS2:
    - inact_edge -> IDLE, ev_double.
    - long_th expire -> LONG, with ev_short and ev_long pulsed in the same cycle.
- en=0: next state IDLE, cnt=0, no ev_* this cycle. A press in progress is abandoned silently.
- rst=1 mid-operation: same effect as reset; any pending event is lost.
- dbl_en cleared while in WAIT2: next cycle -> IDLE with ev_short.
- rpt_en cleared while in LONG: no further repeats; the state is held until release.
- At most one ev_* pulse per cycle, except the PRESS2 long case (ev_short + ev_long together).

Test Plan:
- Reset: rst=1 for 3 clk with act_edge toggling -> all ev_*=0 and busy=0 throughout and one clk after release.
- Short press: long_th=10, dbl_en=0, refclk every 4 clk; act_edge, then inact_edge after 5 ticks -> ev_short exactly 1 clk, the clk after inact_edge; busy falls the same clk.
- Long press and repeat: long_th=10, rpt_en=1, rpt_iv=3; hold 20 ticks -> ev_long on the clk after tick 10; ev_repeat after ticks 13, 16 and 19; no event on release.
- Double click:
  - dbl_en=1, dbl_win=6: press 2 ticks, release, re-press at tick 3, release -> single ev_double, no ev_short.
  - Same first press with no re-press -> ev_short the clk after tick 6 of WAIT2.
- Boundaries:
  - long_th=0 -> ev_long on the first refclk after act_edge.
  - act_edge and inact_edge in the same cycle in IDLE -> stays IDLE.
  - Tick 6 of dbl_win coinciding with act_edge -> PRESS2, no ev_short.
- Enable drop: en=0 during LONG at tick 12 -> IDLE the next clk; no ev_repeat; re-enable and press works normally.
